// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: four-way round-robin arbiter driving the select/enable inputs of the
// downstream 4:1 4-bit mux. A grant is held until its request drops or HOLD_MAX consecutive
// cycles have elapsed. It is then handed to the next requester in rotation on the same edge,
// with no idle bubble. All outputs are registered, so the mux control is glitch-free.
//
// Optional feature (macro MUX_ARB_LOCK_EN): adds a `lock` input. While lock=1 and the
// current holder still requests, hold-limit expiry is ignored.
//
// Parameters:
//   HOLD_MAX  maximum consecutive cycles one grant is held (1..2^CNT_W-1)
//   CNT_W     hold counter width
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   req   in   [3:0] request lines (0=a, 1=b, 2=c, 3=d)
//   lock  in   hold-limit override (MUX_ARB_LOCK_EN only)
//   sel   out  [1:0] mux select, index of the current grantee
//   en    out  mux enable, 1 while a grant is active
//   gnt   out  [3:0] one-hot grant, (1<<sel) when en=1, else 0
module mux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
`ifdef MUX_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [1:0] sel,
  output logic       en,
  output logic [3:0] gnt
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [CNT_W-1:0] HoldMaxC = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       sel_q, sel_d;
  logic             en_q, en_d;
  logic [3:0]       gnt_q, gnt_d;

  logic       hold_lock;
  logic       any_req;
  logic       at_max;
  logic       rel;
  logic [1:0] winner;

  // Scan base+1, base+2, base+3, then base itself. The first requesting index wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = base;
    found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef MUX_ARB_LOCK_EN
  assign hold_lock = lock & req[sel_q];
`else
  assign hold_lock = 1'b0;
`endif

  assign any_req = |req;
  assign at_max  = (cnt_q == HoldMaxC);
  // last_q tracks sel_q after every grant. Outside reset this equals "search from sel+1".
  assign winner  = rr_pick(last_q, req);
  assign rel     = !req[sel_q] || (at_max && !hold_lock);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    en_d    = en_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StGrant;
          sel_d   = winner;
          last_d  = winner;
          en_d    = 1'b1;
          gnt_d   = 4'b0001 << winner;
          cnt_d   = CntOne;
        end
      end
      StGrant: begin
        if (!rel) begin
          // Saturation only matters when lock overrides expiry.
          cnt_d = at_max ? cnt_q : cnt_q + CntOne;
        end else if (any_req) begin
          sel_d  = winner;
          last_d = winner;
          en_d   = 1'b1;
          gnt_d  = 4'b0001 << winner;
          cnt_d  = CntOne;
        end else begin
          state_d = StIdle;
          en_d    = 1'b0;
          gnt_d   = 4'b0000;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        en_d    = 1'b0;
        gnt_d   = 4'b0000;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 2'b11;  // index 0 gets first priority after reset
      sel_q   <= 2'b00;
      en_q    <= 1'b0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
    end
  end

  assign sel = sel_q;
  assign en  = en_q;
  assign gnt = gnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed testbench for mux_rr_arbiter (HOLD_MAX=4). Lock scenarios run only when
// MUX_ARB_LOCK_EN is defined.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       lock;
  logic [1:0] sel;
  logic       en;
  logic [3:0] gnt;

  int checks = 0;
  int errors = 0;

  mux_rr_arbiter #(
    .HOLD_MAX(4),
    .CNT_W   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
`ifdef MUX_ARB_LOCK_EN
    .lock(lock),
`endif
    .sel (sel),
    .en  (en),
    .gnt (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare all three outputs against one expected grant state.
  task automatic expect_out(input string tag, input logic e, input logic [1:0] s,
                            input logic [3:0] g);
    check({tag, ".en"}, 32'(en), 32'(e));
    check({tag, ".sel"}, 32'(sel), 32'(s));
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    lock = 1'b0;
    #2;
    expect_out("reset", 1'b0, 2'd0, 4'b0000);
    tick();
    rst = 1'b0;

    // Single requester: held indefinitely via re-grant, no en gap.
    req = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      tick();
      expect_out($sformatf("solo0[%0d]", i), 1'b1, 2'd0, 4'b0001);
    end
    req = 4'b0000;
    tick();
    expect_out("solo0_drop", 1'b0, 2'd0, 4'b0000);

    // Two requesters alternate every 4 cycles, back to back.
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 9; i++) begin
      logic [1:0] s;
      s = (i >= 4 && i < 8) ? 2'd1 : 2'd0;
      tick();
      expect_out($sformatf("pair[%0d]", i), 1'b1, s, 4'b0001 << s);
    end
    req = 4'b0000;
    tick();
    expect_out("pair_idle", 1'b0, 2'd0, 4'b0000);

    // Requester 2 for two cycles, then drop: idle with sel retained.
    req = 4'b0100;
    tick();
    expect_out("c_1", 1'b1, 2'd2, 4'b0100);
    tick();
    expect_out("c_2", 1'b1, 2'd2, 4'b0100);
    req = 4'b0000;
    tick();
    expect_out("c_drop", 1'b0, 2'd2, 4'b0000);
    tick();
    expect_out("c_idle", 1'b0, 2'd2, 4'b0000);

    // All requesting: 0,1,2,3,0 each 4 cycles.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      logic [1:0] s;
      s = 2'((i / 4) % 4);
      tick();
      expect_out($sformatf("all[%0d]", i), 1'b1, s, 4'b0001 << s);
    end

    // Holder 1 drops while only 3 requests: skip to 3 on the next edge.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) tick();
    expect_out("skip_pre", 1'b1, 2'd1, 4'b0010);
    req = 4'b1000;
    tick();
    expect_out("skip_to3", 1'b1, 2'd3, 4'b1000);

    // Asynchronous reset mid-grant (sel=2, count=3) clears outputs without an edge.
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    tick();
    expect_out("mid_pre", 1'b1, 2'd2, 4'b0100);
    rst = 1'b1;
    #1;
    expect_out("mid_rst", 1'b0, 2'd0, 4'b0000);
    req = 4'b0000;
    tick();
    rst = 1'b0;

    // After reset index 0 has priority over 3; 3 follows after the hold limit.
    req = 4'b1001;
    tick();
    expect_out("pri0", 1'b1, 2'd0, 4'b0001);
    tick();
    tick();
    tick();
    expect_out("pri0_hold", 1'b1, 2'd0, 4'b0001);
    tick();
    expect_out("pri_then3", 1'b1, 2'd3, 4'b1000);

`ifdef MUX_ARB_LOCK_EN
    // Lock keeps holder 0 beyond the limit; releasing lock hands over at once.
    do_reset();
    req  = 4'b0011;
    lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_out($sformatf("lock[%0d]", i), 1'b1, 2'd0, 4'b0001);
    end
    lock = 1'b0;
    tick();
    expect_out("unlock", 1'b1, 2'd1, 4'b0010);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
